// File: rtl/frame_ram_writer_if.sv
// Bundle hand-over and RAM write port of the frame RAM writer.
// master = producer/RAM side, slave = the writer itself.
interface frame_ram_writer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 19
);
    // A bundle transfers on a rising edge where in_valid_s & in_ready_s.
    // in_valid_s is ignored while in_ready_s is low, and d1..d10 only need
    // to be stable at the transfer edge. in_ready_s does not depend on in_valid_s.
    logic              in_valid_s;
    logic              in_ready_s;
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
    logic [DATA_W-1:0] d3;
    logic [DATA_W-1:0] d4;
    logic [DATA_W-1:0] d5;
    logic [DATA_W-1:0] d6;
    logic [DATA_W-1:0] d7;
    logic [DATA_W-1:0] d8;
    logic [DATA_W-1:0] d9;
    logic [DATA_W-1:0] d10;
    logic              we_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [DATA_W-1:0] wr_data_s;

    modport master (
        output in_valid_s, d1, d2, d3, d4, d5, d6, d7, d8, d9, d10,
        input  in_ready_s, we_s, wr_addr_s, wr_data_s
    );

    modport slave (
        input  in_valid_s, d1, d2, d3, d4, d5, d6, d7, d8, d9, d10,
        output in_ready_s, we_s, wr_addr_s, wr_data_s
    );
endinterface

// File: rtl/frame_ram_writer.sv
// Serializes 10-word pixel bundles into consecutive frame RAM writes with a
// wrapping address. Optional running checksum: FRAME_WRITER_CHECKSUM_EN.
module frame_ram_writer #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 19,
    parameter int WORDS     = 10,
    parameter int MEM_DEPTH = 307200
) (
    input  logic                  clk_s,
    input  logic                  rst_s,
    input  logic                  start_s,
    input  logic                  stop_s,
    input  logic [ADDR_W-1:0]     base_addr_s,
    frame_ram_writer_if.slave     bus,
    output logic                  busy_s,
    output logic                  done_s,
    output logic                  wrap_s,
    output logic [DATA_W-1:0]     checksum_s,
    output logic [1:0]            state_dbg_s
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_WRITE  = 2'd2
    } state_t;

    localparam int              IDX_W      = $clog2(WORDS + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [ADDR_W-1:0] DEPTH_ADDR = ADDR_W'(MEM_DEPTH);
    localparam logic [IDX_W-1:0]  BEATS      = IDX_W'(WORDS);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              stop_lat_q, stop_lat_d;
    // d1 goes straight to the bus on the hand-over edge, so only d2..d10 are held
    logic [DATA_W-1:0] bundle_q [WORDS-1];
    logic [DATA_W-1:0] bundle_d [WORDS-1];
    logic              in_ready_q, in_ready_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              wrap_q, wrap_d;

    logic              hs;
    logic              bundle_end;
    logic [ADDR_W-1:0] ptr_inc;

    assign hs         = (state_q == ST_ACCEPT) && bus.in_valid_s;
    // idx counts beats already issued; reaching WORDS means the bundle is out
    assign bundle_end = (state_q == ST_WRITE) && (idx_q == BEATS);
    assign ptr_inc    = (ptr_q == LAST_ADDR) ? '0 : ptr_q + ADDR_W'(1);

    always_ff @(posedge clk_s) begin
        if (rst_s) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            idx_q      <= '0;
            stop_lat_q <= 1'b0;
            for (int i = 0; i < WORDS - 1; i++) begin
                bundle_q[i] <= '0;
            end
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            idx_q      <= idx_d;
            stop_lat_q <= stop_lat_d;
            bundle_q   <= bundle_d;
            in_ready_q <= in_ready_d;
            we_q       <= we_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wrap_q     <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_s) state_d = ST_ACCEPT;
            end
            ST_ACCEPT: begin
                // a hand-over in the same cycle as stop still takes the bundle
                if (hs)          state_d = ST_WRITE;
                else if (stop_s) state_d = ST_IDLE;
            end
            ST_WRITE: begin
                if (bundle_end) state_d = (stop_lat_q || stop_s) ? ST_IDLE : ST_ACCEPT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ptr_d      = ptr_q;
        idx_d      = idx_q;
        stop_lat_d = stop_lat_q;
        bundle_d   = bundle_q;
        we_d       = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    ptr_d      = (base_addr_s >= DEPTH_ADDR) ? '0 : base_addr_s;
                    idx_d      = '0;
                    stop_lat_d = 1'b0;
                end
            end
            ST_ACCEPT: begin
                if (hs) begin
                    bundle_d[0] = bus.d2;
                    bundle_d[1] = bus.d3;
                    bundle_d[2] = bus.d4;
                    bundle_d[3] = bus.d5;
                    bundle_d[4] = bus.d6;
                    bundle_d[5] = bus.d7;
                    bundle_d[6] = bus.d8;
                    bundle_d[7] = bus.d9;
                    bundle_d[8] = bus.d10;
                    we_d        = 1'b1;
                    wr_addr_d   = ptr_q;
                    wr_data_d   = bus.d1;
                    ptr_d       = ptr_inc;
                    idx_d       = IDX_W'(1);
                    stop_lat_d  = stop_s;
                end else begin
                    stop_lat_d = 1'b0;
                end
            end
            ST_WRITE: begin
                if (!bundle_end) begin
                    we_d       = 1'b1;
                    wr_addr_d  = ptr_q;
                    wr_data_d  = bundle_q[0];
                    for (int i = 0; i < WORDS - 2; i++) begin
                        bundle_d[i] = bundle_q[i+1];
                    end
                    bundle_d[WORDS-2] = '0;
                    ptr_d      = ptr_inc;
                    idx_d      = idx_q + IDX_W'(1);
                    stop_lat_d = stop_lat_q || stop_s;
                end else begin
                    idx_d      = '0;
                    stop_lat_d = 1'b0;
                end
            end
            default: begin
                idx_d      = '0;
                stop_lat_d = 1'b0;
            end
        endcase
    end

    // Registered status follows the state being entered, so it lines up with state_q
    always_comb begin
        in_ready_d = (state_d == ST_ACCEPT);
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_q != ST_IDLE) && (state_d == ST_IDLE);
        wrap_d     = we_d && (wr_addr_d == LAST_ADDR);
    end

`ifdef FRAME_WRITER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if ((state_q == ST_IDLE) && start_s) checksum_d = '0;
        else if (we_q)                       checksum_d = checksum_q + wr_data_q;
    end

    always_ff @(posedge clk_s) begin
        if (rst_s) checksum_q <= '0;
        else       checksum_q <= checksum_d;
    end

    assign checksum_s = checksum_q;
`else
    assign checksum_s = '0;
`endif

    assign bus.in_ready_s = in_ready_q;
    assign bus.we_s       = we_q;
    assign bus.wr_addr_s  = wr_addr_q;
    assign bus.wr_data_s  = wr_data_q;
    assign busy_s         = busy_q;
    assign done_s         = done_q;
    assign wrap_s         = wrap_q;
    assign state_dbg_s    = state_q;

endmodule

// File: tb/tb_frame_ram_writer.sv
// Bench for frame_ram_writer: directed sequence plus random bundles checked
// against an address/data queue model; FRAME_WRITER_CHECKSUM_EN selects checksum expectation.
module tb_frame_ram_writer;
    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 19;
    localparam int WORDS     = 10;
    localparam int MEM_DEPTH = 307200;
`ifdef FRAME_WRITER_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic              clk_s = 1'b0;
    logic              rst_s;
    logic              start_s;
    logic              stop_s;
    logic [ADDR_W-1:0] base_addr_s;
    logic              busy_s;
    logic              done_s;
    logic              wrap_s;
    logic [DATA_W-1:0] checksum_s;
    logic [1:0]        state_dbg_s;

    frame_ram_writer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    frame_ram_writer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .WORDS(WORDS), .MEM_DEPTH(MEM_DEPTH)
    ) dut (
        .clk_s       (clk_s),
        .rst_s       (rst_s),
        .start_s     (start_s),
        .stop_s      (stop_s),
        .base_addr_s (base_addr_s),
        .bus         (bus),
        .busy_s      (busy_s),
        .done_s      (done_s),
        .wrap_s      (wrap_s),
        .checksum_s  (checksum_s),
        .state_dbg_s (state_dbg_s)
    );

    always #5 clk_s = ~clk_s;

    int                          n_vec = 0;
    int                          n_err = 0;
    int                          cyc = 0;
    int                          hs_cyc = 0;
    int                          wrap_cnt = 0;
    int                          m_ptr = 0;
    logic [DATA_W-1:0]           m_sum = '0;
    logic [ADDR_W+DATA_W-1:0]    exp_q[$];
    logic [ADDR_W+DATA_W-1:0]    mon_e;

    always @(posedge clk_s) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before 500us");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_s);
    endtask

    function automatic logic [DATA_W-1:0] exp_sum();
        return m_sum & {DATA_W{CK_EN}};
    endfunction

    task automatic drive_words(input logic [DATA_W-1:0] w [WORDS]);
        bus.d1 = w[0]; bus.d2 = w[1]; bus.d3 = w[2]; bus.d4 = w[3]; bus.d5 = w[4];
        bus.d6 = w[5]; bus.d7 = w[6]; bus.d8 = w[7]; bus.d9 = w[8]; bus.d10 = w[9];
    endtask

    task automatic rand_words(output logic [DATA_W-1:0] w [WORDS]);
        for (int i = 0; i < WORDS; i++) w[i] = DATA_W'($urandom);
    endtask

    task automatic model_push(input logic [DATA_W-1:0] w [WORDS]);
        for (int i = 0; i < WORDS; i++) begin
            exp_q.push_back({ADDR_W'(m_ptr), w[i]});
            m_sum = m_sum + w[i];
            m_ptr = (m_ptr + 1) % MEM_DEPTH;
        end
    endtask

    task automatic check_reset_values();
        check("rst_in_ready", {31'd0, bus.in_ready_s}, 0);
        check("rst_we", {31'd0, bus.we_s}, 0);
        check("rst_wr_addr", 32'(bus.wr_addr_s), 0);
        check("rst_wr_data", 32'(bus.wr_data_s), 0);
        check("rst_busy", {31'd0, busy_s}, 0);
        check("rst_done", {31'd0, done_s}, 0);
        check("rst_wrap", {31'd0, wrap_s}, 0);
        check("rst_checksum", 32'(checksum_s), 0);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (bus.in_ready_s !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("ready_wait", {31'd0, bus.in_ready_s}, 1);
    endtask

    task automatic start_at(input logic [ADDR_W-1:0] base);
        start_s     = 1'b1;
        base_addr_s = base;
        tick();
        start_s     = 1'b0;
        m_ptr       = (int'(base) >= MEM_DEPTH) ? 0 : int'(base);
        m_sum       = '0;
        check("start_busy", {31'd0, busy_s}, 1);
        check("start_ready", {31'd0, bus.in_ready_s}, 1);
    endtask

    // Returns at the negedge of the first write beat.
    task automatic send(input logic [DATA_W-1:0] w [WORDS], input bit stop_hs);
        logic [DATA_W-1:0] junk [WORDS];
        wait_ready();
        bus.in_valid_s = 1'b1;
        drive_words(w);
        stop_s = stop_hs;
        model_push(w);
        hs_cyc = cyc;
        tick();
        bus.in_valid_s = 1'b0;
        stop_s = 1'b0;
        rand_words(junk);
        drive_words(junk);
        check("ready_low", {31'd0, bus.in_ready_s}, 0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_s !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("done_seen", {31'd0, done_s}, 1);
        check("done_gap", 32'(cyc - hs_cyc), 11);
        check("done_busy", {31'd0, busy_s}, 0);
        check("checksum", 32'(checksum_s), 32'(exp_sum()));
        check("queue_empty", 32'(exp_q.size()), 0);
        tick();
        check("done_pulse", {31'd0, done_s}, 0);
    endtask

    // Scoreboard: every write beat must match the head of the expected queue.
    always @(negedge clk_s) begin
        if (rst_s === 1'b0) begin
            if (wrap_s) wrap_cnt++;
            if (bus.we_s) begin
                if (exp_q.size() == 0) begin
                    check("extra_we", {31'd0, bus.we_s}, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wr_addr", 32'(bus.wr_addr_s), 32'(mon_e[ADDR_W+DATA_W-1:DATA_W]));
                    check("wr_data", 32'(bus.wr_data_s), 32'(mon_e[DATA_W-1:0]));
                    check("wrap_beat", {31'd0, wrap_s},
                          {31'd0, (int'(mon_e[ADDR_W+DATA_W-1:DATA_W]) == MEM_DEPTH - 1)});
                    check("ready_in_write", {31'd0, bus.in_ready_s}, 0);
                end
            end else begin
                check("wrap_idle", {31'd0, wrap_s}, 0);
            end
        end
    end

    initial begin
        logic [DATA_W-1:0] w [WORDS];
        int                hs_b [3];
        int                pick;
        int                nb;
        logic [ADDR_W-1:0] base;

        rst_s = 1'b1;
        start_s = 1'b0;
        stop_s = 1'b0;
        base_addr_s = '0;
        bus.in_valid_s = 1'b0;
        for (int i = 0; i < WORDS; i++) w[i] = '0;
        drive_words(w);
        repeat (3) tick();
        check_reset_values();
        rst_s = 1'b0;
        tick();

        // single bundle 1..10 at base 0, stop together with the hand-over
        start_at(19'h0);
        for (int i = 0; i < WORDS; i++) w[i] = DATA_W'(i + 1);
        send(w, 1'b1);
        wait_done();
        check("single_sum_model", 32'(m_sum), 32'h37);

        // frame wrap, start ignored mid-bundle, stop on 3rd beat of next bundle
        wrap_cnt = 0;
        start_at(19'h4AFFC);
        for (int i = 0; i < WORDS; i++) w[i] = DATA_W'(16'hA0A0 + i);
        send(w, 1'b0);
        repeat (4) tick();
        start_s = 1'b1;
        base_addr_s = 19'h00123;
        tick();
        start_s = 1'b0;
        rand_words(w);
        send(w, 1'b0);
        tick();
        tick();
        stop_s = 1'b1;
        tick();
        stop_s = 1'b0;
        wait_done();
        check("wrap_count", 32'(wrap_cnt), 1);

        // back-to-back: valid held high for three bundles, then stop in ACCEPT
        start_at(19'h0);
        bus.in_valid_s = 1'b1;
        for (int b = 0; b < 3; b++) begin
            wait_ready();
            rand_words(w);
            drive_words(w);
            model_push(w);
            hs_b[b] = cyc;
            tick();
        end
        bus.in_valid_s = 1'b0;
        check("b2b_gap0", 32'(hs_b[1] - hs_b[0]), 11);
        check("b2b_gap1", 32'(hs_b[2] - hs_b[1]), 11);
        wait_ready();
        stop_s = 1'b1;
        tick();
        stop_s = 1'b0;
        check("accept_stop_done", {31'd0, done_s}, 1);
        check("accept_stop_busy", {31'd0, busy_s}, 0);
        check("b2b_queue_empty", 32'(exp_q.size()), 0);
        check("b2b_last_ptr", 32'(m_ptr), 30);

        // out-of-range base folds to address 0
        start_at(19'h4B000);
        rand_words(w);
        send(w, 1'b1);
        wait_done();

        // reset after the 4th beat abandons the bundle
        start_at(19'h00020);
        rand_words(w);
        send(w, 1'b0);
        repeat (3) tick();
        rst_s = 1'b1;
        tick();
        check_reset_values();
        exp_q.delete();
        rst_s = 1'b0;
        repeat (4) tick();
        check("post_rst_idle", {31'd0, busy_s}, 0);
        start_at(19'h00010);
        rand_words(w);
        send(w, 1'b1);
        wait_done();

        // random bases and bundle counts, stop either with hand-over or mid-bundle
        for (int r = 0; r < 8; r++) begin
            pick = $urandom_range(0, 3);
            if (pick == 0)      base = ADDR_W'(MEM_DEPTH - $urandom_range(1, 12));
            else if (pick == 1) base = ADDR_W'($urandom_range(MEM_DEPTH, (1 << ADDR_W) - 1));
            else                base = ADDR_W'($urandom_range(0, MEM_DEPTH - 1));
            start_at(base);
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) begin
                repeat ($urandom_range(0, 2)) tick();
                rand_words(w);
                if (b == nb - 1 && (r % 2) == 0) begin
                    send(w, 1'b1);
                end else begin
                    send(w, 1'b0);
                    if (b == nb - 1) begin
                        repeat ($urandom_range(0, 8)) tick();
                        stop_s = 1'b1;
                        tick();
                        stop_s = 1'b0;
                    end
                end
            end
            wait_done();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/frame_ram_writer.md
# frame_ram_writer

Writes 10-word pixel bundles into the single-port frame RAM; the write-side counterpart of the 10-word frame ROM read port. An upstream producer hands over a bundle of ten 16-bit words (d1..d10) through a valid/ready handshake. The block serializes the bundle into ten consecutive RAM writes at an auto-incrementing 19-bit address. The address wraps at the end of the 640x480 frame.

## Interface
- DATA_W, 16, width of each pixel word
- ADDR_W, 19, RAM address width
- WORDS, 10, words per bundle (d1..d10)
- MEM_DEPTH, 307200, RAM depth in words (640*480); valid addresses 0..MEM_DEPTH-1
- clk_s  in  1  single clock; all logic on rising edge
- rst_s  in  1  synchronous, active-high reset
- start_s  in  1  one-cycle pulse in IDLE; loads base_addr_s and arms the writer
- stop_s  in  1  request return to IDLE after the current bundle
- base_addr_s  in  ADDR_W  first write address, sampled on start_s
- in_valid_s  in  1  bundle d1..d10 valid
- in_ready_s  out  1  writer can accept a bundle
- d1..d10  in  DATA_W each  bundle words; d1 is written first
- we_s  out  1  RAM write enable
- wr_addr_s  out  ADDR_W  RAM write address
- wr_data_s  out  DATA_W  RAM write data
- busy_s  out  1  high in any state other than IDLE
- done_s  out  1  one-cycle pulse on return to IDLE
- wrap_s  out  1  one-cycle pulse with the write to address MEM_DEPTH-1
- checksum_s  out  DATA_W  running sum of written words (see Configuration)

## Operation
- FSM states: IDLE, ACCEPT, WRITE. Reset state is IDLE.
- IDLE:
  - start_s loads ptr = base_addr_s, then goes to ACCEPT.
  - If base_addr_s >= MEM_DEPTH, ptr loads 0.
  - start_s is ignored in every other state.
- ACCEPT:
  - in_ready_s=1.
  - in_valid_s & in_ready_s captures d1..d10 into a bundle buffer, sets idx=0, goes to WRITE.
  - stop_s without a handshake goes to IDLE.
  - If stop_s and a handshake occur in the same cycle, the handshake wins: the bundle is captured and stop is latched.
- WRITE, one word per cycle:
  - we_s=1, wr_addr_s=ptr, wr_data_s=buffer[idx].
  - ptr increments; from MEM_DEPTH-1 it wraps to 0.
  - After idx=WORDS-1, goes to ACCEPT, or to IDLE if stop is latched.
- stop_s during WRITE is latched; the bundle always completes.
- The ptr persists across bundles; only start_s reloads it.
- Address arithmetic is unsigned, ADDR_W bits, with explicit wrap at MEM_DEPTH (not at 2^ADDR_W).

## Timing
- All outputs are registered.
- Reset values:
  - in_ready_s=0, we_s=0, wr_addr_s=0, wr_data_s=0
  - busy_s=0, done_s=0, wrap_s=0, checksum_s=0
  - ptr=0, idx=0, stop latch=0
- start_s at edge k:
  - busy_s=1 and in_ready_s=1 from cycle k+1.
- Handshake at edge h:
  - in_ready_s=0 from cycle h+1.
  - we_s=1 on cycles h+1..h+10, carrying d1..d10 at ptr..ptr+9 (mod MEM_DEPTH).
  - in_ready_s=1 again on cycle h+11.
  - Bundle period is 11 cycles minimum.
- Stop paths:
  - Latched stop: done_s pulses on cycle h+11 and busy_s=0 on the same cycle.
  - stop_s in ACCEPT at edge s: done_s=1 on cycle s+1.
- wrap_s is high in the same cycle as the we_s beat whose wr_addr_s=MEM_DEPTH-1.
- in_valid_s while in_ready_s=0 has no effect; d1..d10 need only be stable at the handshake edge.
- rst_s mid-operation: reset values on the next edge. A partially written bundle is abandoned with no further we_s, and no done_s pulse.

## Configuration
- Macro: FRAME_WRITER_CHECKSUM_EN.
- Defined: checksum_s is cleared on start_s. It adds wr_data_s (mod 2^DATA_W) on every we_s beat and updates the cycle after the beat.
- Undefined: checksum_s is constant 0, and no adder or register is synthesized.
- All other behaviour is identical with and without the macro.

## Test plan
- Single bundle: reset, start_s with base 19'h0, one bundle d1..d10=16'h0001..16'h000A, stop_s.
  - Expect we_s for exactly 10 cycles at addresses 0..9 with data 1..10.
  - Then done_s one pulse; checksum_s=16'h0037 with the macro, 0 without.
- Frame wrap: base 19'h4AFFC, one bundle of 16'hA0A0..16'hA0A9.
  - Expect writes at 4AFFC..4AFFF, then 0..5.
  - wrap_s exactly once, on the 4AFFF beat.
- Back-to-back: in_valid_s held high for 3 bundles.
  - Expect addresses 0..29 contiguous and handshakes exactly 11 cycles apart.
  - in_ready_s low during every WRITE.
- Stop and start rules:
  - stop_s asserted on the 3rd beat of a bundle: all 10 writes complete, then done_s, then IDLE.
  - start_s pulsed during WRITE: ptr is unchanged.
- Reset mid-bundle: rst_s after the 4th beat.
  - Next cycle all outputs are at reset values, with no further we_s.
  - A fresh start_s with base 19'h10 writes from 19'h10.
- Out-of-range base: start_s with base 19'h4B000 (= MEM_DEPTH) -> first write is at address 0.
